debug_baud_sync_tx: RTL

DEBUG_BAUD_SYNC_TX -- requirements
Module: debug_baud_sync_tx

---
 rtl/debug_uart_pkg.sv | 28 ++
 rtl/debug_baud_tick.sv | 37 +++
 rtl/debug_baud_sync_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/debug_uart_pkg.sv
// Shared definitions for the debug UART transmit path: FSM states, bit timing
// constants and the autobaud-compatible bit period helper.
package debug_uart_pkg;

    localparam int unsigned BIT_SCALE    = 32;
    localparam int unsigned HALF_BUCKET  = 16;
    localparam int unsigned FRAME_BITS   = 10;
    localparam int unsigned DIV_W        = 8;
    localparam int unsigned BIT_CNT_W    = 13;
    localparam int unsigned GUARD_CNT_W  = 15;
    localparam int unsigned SYNC_CNT_W   = 4;
    localparam int unsigned BIT_IDX_W    = 4;
    localparam logic [7:0]  SYNC_PATTERN = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GUARD = 3'd4
    } uart_state_e;

    // Centred in the receiver's 32-clock bucket so pulse_width[12:5] == div.
    function automatic logic [BIT_CNT_W-1:0] bit_period(input logic [DIV_W-1:0] d);
        return BIT_CNT_W'(d) * BIT_CNT_W'(BIT_SCALE) + BIT_CNT_W'(HALF_BUCKET);
    endfunction

endpackage

// File: rtl/debug_baud_tick.sv
// Bit-period timer: emits a one-cycle tick at the end of every bit period
// of 32*div_q+16 clocks; restart holds the count at zero.
module debug_baud_tick
    import debug_uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_q,
    input  logic             restart,
    output logic             tick_c
);

    logic [BIT_CNT_W-1:0] cnt_q;
    logic [BIT_CNT_W-1:0] cnt_d;
    logic [BIT_CNT_W-1:0] last_c;
    logic                 at_end_c;

    assign last_c   = bit_period(div_q) - BIT_CNT_W'(1);
    assign at_end_c = (cnt_q >= last_c);
    assign tick_c   = at_end_c && !restart;

    always_comb begin
        cnt_d = cnt_q + BIT_CNT_W'(1);
        if (restart || at_end_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_baud_sync_tx.sv
// Debug UART transmitter (8N1) with autobaud training: sends SYNC_BYTES x 0x55
// followed by a guard idle period, then ordinary data bytes.
module debug_baud_sync_tx
    import debug_uart_pkg::*;
#(
    parameter int unsigned SYNC_BYTES = 4,
    parameter int unsigned GUARD_CLKS = 16384
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div,
    input  logic             sync_req,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic             sync_done
);

    uart_state_e            state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       div_pend_q, div_pend_d;
    logic                   sync_pend_q, sync_pend_d;
    logic                   sync_mode_q, sync_mode_d;
    logic [SYNC_CNT_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [GUARD_CNT_W-1:0] guard_cnt_q, guard_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   sync_done_q, sync_done_d;

    logic tick_c;
    logic restart_c;
    logic div_ok_c;
    logic sync_go_c;
    logic accept_c;

    // A pending sync wins over data, including a request arriving this cycle.
    assign div_ok_c  = (div_pend_q != '0);
    assign sync_go_c = div_ok_c && (sync_pend_q || sync_req);
    assign tx_ready  = (state_q == ST_IDLE) && div_ok_c && !sync_pend_q && !sync_req;
    assign accept_c  = tx_valid && tx_ready;
    assign restart_c = (state_q == ST_IDLE) || (state_q == ST_GUARD);

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign sync_done = sync_done_q;

    debug_baud_tick u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_q   (div_q),
        .restart (restart_c),
        .tick_c  (tick_c)
    );

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        div_pend_d  = div_pend_q;
        sync_pend_d = sync_pend_q || sync_req;
        sync_mode_d = sync_mode_q;
        sync_cnt_d  = sync_cnt_q;
        bit_idx_d   = bit_idx_q;
        guard_cnt_d = guard_cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;

        if (div_wr && (div != '0)) begin
            div_pend_d = div;
        end

        unique case (state_q)
            ST_IDLE: begin
                div_d = div_pend_q;
                if (sync_go_c) begin
                    state_d     = ST_START;
                    shreg_d     = SYNC_PATTERN;
                    sync_mode_d = 1'b1;
                    sync_cnt_d  = SYNC_CNT_W'(SYNC_BYTES - 1);
                    sync_pend_d = 1'b0;
                    bit_idx_d   = '0;
                    tx_d        = 1'b0;
                end else if (accept_c) begin
                    state_d     = ST_START;
                    shreg_d     = tx_data;
                    sync_mode_d = 1'b0;
                    bit_idx_d   = '0;
                    tx_d        = 1'b0;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    state_d   = ST_DATA;
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    tx_d      = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(FRAME_BITS - 2)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (sync_mode_q && (sync_cnt_q != '0)) begin
                        state_d    = ST_START;
                        div_d      = div_pend_q;
                        shreg_d    = SYNC_PATTERN;
                        sync_cnt_d = sync_cnt_q - SYNC_CNT_W'(1);
                        bit_idx_d  = '0;
                        tx_d       = 1'b0;
                    end else if (sync_mode_q) begin
                        state_d     = ST_GUARD;
                        sync_mode_d = 1'b0;
                        guard_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GUARD: begin
                // A sync queued during the guard restarts training with no data slot.
                if (guard_cnt_q == GUARD_CNT_W'(GUARD_CLKS - 1)) begin
                    if (sync_go_c) begin
                        state_d     = ST_START;
                        div_d       = div_pend_q;
                        shreg_d     = SYNC_PATTERN;
                        sync_mode_d = 1'b1;
                        sync_cnt_d  = SYNC_CNT_W'(SYNC_BYTES - 1);
                        sync_pend_d = 1'b0;
                        bit_idx_d   = '0;
                        tx_d        = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    guard_cnt_d = guard_cnt_q + GUARD_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        sync_done_d = (state_d == ST_GUARD) && (guard_cnt_d == GUARD_CNT_W'(GUARD_CLKS - 1));
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            div_pend_q  <= '0;
            sync_pend_q <= 1'b0;
            sync_mode_q <= 1'b0;
            sync_cnt_q  <= '0;
            bit_idx_q   <= '0;
            guard_cnt_q <= '0;
            shreg_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            sync_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            div_pend_q  <= div_pend_d;
            sync_pend_q <= sync_pend_d;
            sync_mode_q <= sync_mode_d;
            sync_cnt_q  <= sync_cnt_d;
            bit_idx_q   <= bit_idx_d;
            guard_cnt_q <= guard_cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            sync_done_q <= sync_done_d;
        end
    end

endmodule
